// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit: walks fetch/decode/execute/memory/writeback
// and drives datapath selects, enables, write strobes and ALU control.
// Opcode class encoding: 0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J, 6-7 invalid.
// Function class encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5-7 invalid.
module mc_control_fsm #(
  parameter bit HALT_ON_INVALID = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] op,
  input  logic [2:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       instr_done,
  output logic       halted
);

  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_LW    = 3'd1;
  localparam logic [2:0] OP_SW    = 3'd2;
  localparam logic [2:0] OP_BEQ   = 3'd3;
  localparam logic [2:0] OP_ADDI  = 3'd4;
  localparam logic [2:0] OP_J     = 3'd5;

  localparam logic [2:0] FU_ADD = 3'd0;
  localparam logic [2:0] FU_SUB = 3'd1;
  localparam logic [2:0] FU_AND = 3'd2;
  localparam logic [2:0] FU_OR  = 3'd3;
  localparam logic [2:0] FU_SLT = 3'd4;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTE,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
  } state_t;

  state_t state_q, state_d;
  // Remembers LW vs SW from DECODE so MEMADR does not depend on a live op.
  logic   is_lw_q, is_lw_d;
  logic   pc_write, branch, bad_instr;

  function automatic logic funct_valid(input logic [2:0] f);
    return (f <= FU_SLT);
  endfunction

  function automatic logic [2:0] alu_for_funct(input logic [2:0] f);
    case (f)
      FU_ADD:  return ALU_ADD;
      FU_SUB:  return ALU_SUB;
      FU_AND:  return ALU_AND;
      FU_OR:   return ALU_OR;
      FU_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // State and LW/SW flag registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      is_lw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_lw_q <= is_lw_d;
    end
  end

  // Next-state logic and Moore outputs decoded from the current state.
  always_comb begin
    state_d     = state_q;
    is_lw_d     = is_lw_q;
    iord        = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    pc_src      = 2'b00;
    instr_done  = 1'b0;
    halted      = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    bad_instr   = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target into ALUOut.
        alu_src_b = 2'b11;
        is_lw_d   = (op == OP_LW);
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct_valid(funct)) state_d = S_EXECUTE;
            else                    bad_instr = 1'b1;
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: bad_instr = 1'b1;
        endcase
        if (bad_instr) begin
          if (HALT_ON_INVALID) begin
            state_d = S_HALT;
          end else begin
            state_d    = S_FETCH;
            instr_done = 1'b1;
          end
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = is_lw_q ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = alu_for_funct(funct);
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        branch      = 1'b1;
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        // Unreachable encodings: everything off, recover through FETCH.
        alu_control = 3'b000;
        state_d     = S_FETCH;
      end
    endcase
  end

  // Only the branch term sees zero, so it is ignored outside BRANCH.
  assign pc_en = pc_write | (branch & zero);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: two instances (halt / drop on invalid) driven in
// lockstep and compared against a per-instruction cycle table model.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] op, funct;
  logic       zero;

  logic       h_iord, h_irw, h_mw, h_rw, h_rd, h_m2r, h_sa, h_pe, h_done, h_hlt;
  logic [1:0] h_sb, h_ps;
  logic [2:0] h_alu;
  logic       d_iord, d_irw, d_mw, d_rw, d_rd, d_m2r, d_sa, d_pe, d_done, d_hlt;
  logic [1:0] d_sb, d_ps;
  logic [2:0] d_alu;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.HALT_ON_INVALID(1'b1)) u_halt (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(h_iord), .ir_write(h_irw), .mem_write(h_mw), .reg_write(h_rw),
    .reg_dst(h_rd), .mem_to_reg(h_m2r), .alu_src_a(h_sa), .alu_src_b(h_sb),
    .alu_control(h_alu), .pc_src(h_ps), .pc_en(h_pe), .instr_done(h_done),
    .halted(h_hlt)
  );

  mc_control_fsm #(.HALT_ON_INVALID(1'b0)) u_drop (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(d_iord), .ir_write(d_irw), .mem_write(d_mw), .reg_write(d_rw),
    .reg_dst(d_rd), .mem_to_reg(d_m2r), .alu_src_a(d_sa), .alu_src_b(d_sb),
    .alu_control(d_alu), .pc_src(d_ps), .pc_en(d_pe), .instr_done(d_done),
    .halted(d_hlt)
  );

  // Output vector: {iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg,
  //                 alu_src_a, alu_src_b, alu_control, pc_src, pc_en, instr_done, halted}
  logic [16:0] obs_h, obs_d;
  assign obs_h = {h_iord, h_irw, h_mw, h_rw, h_rd, h_m2r, h_sa, h_sb, h_alu, h_ps, h_pe, h_done, h_hlt};
  assign obs_d = {d_iord, d_irw, d_mw, d_rw, d_rd, d_m2r, d_sa, d_sb, d_alu, d_ps, d_pe, d_done, d_hlt};

  function automatic logic [16:0] mk(bit io, bit irw, bit mw, bit rw, bit rd, bit m2r, bit sa,
                                     logic [1:0] sb, logic [2:0] alu, logic [1:0] ps,
                                     bit pe, bit dn, bit hl);
    return {io, irw, mw, rw, rd, m2r, sa, sb, alu, ps, pe, dn, hl};
  endfunction

  function automatic logic [16:0] fetch_v();
    return mk(0, 1, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 1, 0, 0);
  endfunction

  function automatic logic [16:0] halt_v();
    return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 0, 1);
  endfunction

  function automatic bit is_invalid(logic [2:0] o, logic [2:0] f);
    return (o > 3'd5) || (o == 3'd0 && f > 3'd4);
  endfunction

  function automatic int instr_len(logic [2:0] o);
    case (o)
      3'd1:          return 5;
      3'd0, 3'd2, 3'd4: return 4;
      3'd3, 3'd5:    return 3;
      default:       return 2;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(logic [2:0] f);
    case (f)
      3'd1:    return 3'b110;
      3'd2:    return 3'b000;
      3'd3:    return 3'b001;
      3'd4:    return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Expected outputs in cycle k (0 = FETCH) of an instruction.
  function automatic logic [16:0] expect_out(logic [2:0] o, logic [2:0] f, int k, logic z, bit hmode);
    bit bad;
    bad = is_invalid(o, f);
    if (k == 0) return fetch_v();
    if (k == 1) return mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0, bad && !hmode, 0);
    if (bad) return hmode ? halt_v() : fetch_v();
    case (o)
      3'd1: begin
        if (k == 2) return mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0, 0);
        if (k == 3) return mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 0, 0);
        return mk(0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0, 1, 0);
      end
      3'd2: begin
        if (k == 2) return mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0, 0);
        return mk(1, 0, 1, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 1, 0);
      end
      3'd0: begin
        if (k == 2) return mk(0, 0, 0, 0, 0, 0, 1, 2'b00, alu_of(f), 2'b00, 0, 0, 0);
        return mk(0, 0, 0, 1, 1, 0, 0, 2'b00, 3'b010, 2'b00, 0, 1, 0);
      end
      3'd3: return mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, z, 1, 0);
      3'd4: begin
        if (k == 2) return mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0, 0);
        return mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 1, 0);
      end
      default: return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b10, 1, 1, 0);
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    op = 3'd0; funct = 3'd0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_h !== fetch_v()) begin errors++; $display("FAIL reset_h got %h exp %h", obs_h, fetch_v()); end
    checks++;
    if (obs_d !== fetch_v()) begin errors++; $display("FAIL reset_d got %h exp %h", obs_d, fetch_v()); end
    reset = 1'b0;
  endtask

  // Runs one valid instruction; op/funct are randomised outside sampling cycles.
  task automatic test_instr(logic [2:0] o, logic [2:0] f);
    logic [16:0] e;
    int len;
    len = instr_len(o);
    for (int k = 0; k < len; k++) begin
      op    = (k == 1) ? o : 3'($urandom_range(0, 7));
      funct = (k == 1 || (o == 3'd0 && k == 2)) ? f : 3'($urandom_range(0, 7));
      zero  = 1'($urandom_range(0, 1));
      #2;
      if (o == 3'd3 && k == 2) begin
        for (int zi = 0; zi < 2; zi++) begin
          zero = (zi == 0);
          #1;
          e = expect_out(o, f, k, zero, 1'b1);
          checks++;
          if (obs_h !== e) begin errors++; $display("FAIL beq_h op=%0d k=%0d z=%0b got %h exp %h", o, k, zero, obs_h, e); end
          checks++;
          if (obs_d !== e) begin errors++; $display("FAIL beq_d op=%0d k=%0d z=%0b got %h exp %h", o, k, zero, obs_d, e); end
        end
      end else begin
        e = expect_out(o, f, k, zero, 1'b1);
        checks++;
        if (obs_h !== e) begin errors++; $display("FAIL instr_h op=%0d fn=%0d k=%0d got %h exp %h", o, f, k, obs_h, e); end
        checks++;
        if (obs_d !== e) begin errors++; $display("FAIL instr_d op=%0d fn=%0d k=%0d got %h exp %h", o, f, k, obs_d, e); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [16:0] e;
    for (int k = 0; k < 3; k++) begin
      op = (k == 1) ? 3'd1 : 3'($urandom_range(0, 7));
      funct = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
    e = expect_out(3'd1, 3'd0, 3, 1'b0, 1'b1);
    checks++;
    if (obs_h !== e) begin errors++; $display("FAIL memrd_h got %h exp %h", obs_h, e); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs_h !== fetch_v()) begin errors++; $display("FAIL async_reset_h got %h exp %h", obs_h, fetch_v()); end
    checks++;
    if (obs_d !== fetch_v()) begin errors++; $display("FAIL async_reset_d got %h exp %h", obs_d, fetch_v()); end
    @(posedge clk); #1;
    reset = 1'b0;
    test_instr(3'd1, 3'd0);
  endtask

  task automatic test_invalid(logic [2:0] o, logic [2:0] f);
    logic [16:0] e;
    for (int k = 0; k < 2; k++) begin
      op = (k == 1) ? o : 3'($urandom_range(0, 7));
      funct = (k == 1) ? f : 3'($urandom_range(0, 7));
      #2;
      e = expect_out(o, f, k, zero, 1'b1);
      checks++;
      if (obs_h !== e) begin errors++; $display("FAIL inv_h op=%0d k=%0d got %h exp %h", o, k, obs_h, e); end
      e = expect_out(o, f, k, zero, 1'b0);
      checks++;
      if (obs_d !== e) begin errors++; $display("FAIL inv_d op=%0d k=%0d got %h exp %h", o, k, obs_d, e); end
      @(posedge clk); #1;
    end
    #2;
    checks++;
    if (obs_d !== fetch_v()) begin errors++; $display("FAIL drop_fetch got %h exp %h", obs_d, fetch_v()); end
    for (int c = 0; c < 21; c++) begin
      checks++;
      if (obs_h !== halt_v()) begin errors++; $display("FAIL halt_hold c=%0d got %h exp %h", c, obs_h, halt_v()); end
      @(posedge clk); #1;
      op = 3'($urandom_range(0, 7)); funct = 3'($urandom_range(0, 7)); zero = 1'($urandom_range(0, 1));
      #2;
    end
    do_reset();
  endtask

  task automatic test_random(int n);
    for (int i = 0; i < n; i++)
      test_instr(3'($urandom_range(0, 5)), 3'($urandom_range(0, 4)));
  endtask

  initial begin
    test_reset();
    test_instr(3'd1, 3'd0);  // LW
    test_instr(3'd0, 3'd1);  // RTYPE SUB
    test_instr(3'd0, 3'd4);  // RTYPE SLT
    test_instr(3'd3, 3'd0);  // BEQ
    test_instr(3'd2, 3'd0);  // SW
    test_instr(3'd4, 3'd0);  // ADDI
    test_instr(3'd5, 3'd0);  // J
    test_reset_mid();
    test_invalid(3'd6, 3'd0);
    test_invalid(3'd0, 3'd5);
    test_invalid(3'd7, 3'd2);
    test_random(60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
